// File: rtl/bmp_loader.sv
// Bitmap frame loader: assembles WORDS 32-bit words into a bitmap, strobes the
// compare accelerator, waits (with watchdog) for its result and hands it on.
module bmp_loader #(
  parameter int unsigned WORDS   = 48,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic [WORDS*32-1:0]   bitmap,
  output logic                  wren,
  input  logic [15:0]           acc_result,
  input  logic                  acc_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [15:0]           res_data,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  timeout
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, RESP} state_t;

  state_t         state, state_n;
  logic [5:0]     cnt, cnt_n;
  logic [WDW-1:0] wd, wd_n;
  logic           accept, ferr_n, tout_n, capture;

  // Gated by rst so the source sees not-ready throughout the reset cycle.
  assign in_ready = (state == FILL) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wd_n    = wd;
    ferr_n  = 1'b0;
    tout_n  = 1'b0;
    capture = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (cnt == 6'(WORDS - 1)) begin
            cnt_n = '0;
            if (in_last) state_n = LAUNCH;
            else         ferr_n  = 1'b1;
          end else if (in_last) begin
            cnt_n  = '0;
            ferr_n = 1'b1;
          end else begin
            cnt_n = cnt + 6'd1;
          end
        end
      end
      LAUNCH: begin
        // acc_done is deliberately not looked at here: it may be left over.
        state_n = WAIT;
        wd_n    = '0;
      end
      WAIT: begin
        if (acc_done) begin
          capture = 1'b1;
          state_n = RESP;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          tout_n  = 1'b1;
          state_n = FILL;
        end else begin
          wd_n = wd + WDW'(1);
        end
      end
      RESP: begin
        if (res_ready) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      wd        <= '0;
      bitmap    <= '0;
      wren      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wd        <= wd_n;
      if (accept) bitmap[{cnt, 5'b0} +: 32] <= in_data;
      if (capture) res_data <= acc_result;
      // Registered outputs are decoded from the next state so they line up
      // with the state they describe.
      wren      <= (state_n == LAUNCH);
      res_valid <= (state_n == RESP);
      frame_err <= ferr_n;
      timeout   <= tout_n;
      busy      <= !((state_n == FILL) && (cnt_n == 6'd0));
    end
  end

endmodule

// File: doc/bmp_loader.md
BMP_LOADER -- requirements
Module: bmp_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 48, meaning the number of input words per bitmap frame (fixed: WORDS*32 = 1536).
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of cycles spent in WAIT before abandoning the frame.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the source is presenting an input word.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept an input word this cycle.
REQ-007 The block SHALL have port in_data, input, 32 bits, the bitmap word.
REQ-008 The block SHALL have port in_last, input, 1 bit, which marks the final word of a frame.
REQ-009 The block SHALL have port bitmap, output, 1536 bits, the assembled bitmap driven to the compare accelerator.
REQ-010 The block SHALL have port wren, output, 1 bit, a load strobe to the compare accelerator.
REQ-011 The block SHALL have port acc_result, input, 16 bits, the compare accelerator result.
REQ-012 The block SHALL have port acc_done, input, 1 bit, the compare accelerator completion flag.
REQ-013 The block SHALL have port res_valid, output, 1 bit, meaning a result is available.
REQ-014 The block SHALL have port res_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-015 The block SHALL have port res_data, output, 16 bits, the captured result.
REQ-016 The block SHALL have port busy, output, 1 bit, asserted in any state other than FILL with the word count at 0.
REQ-017 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse on framing error.
REQ-018 The block SHALL have port timeout, output, 1 bit, a one-cycle pulse when the WAIT watchdog expires.

Function
REQ-019 The block SHALL implement a state machine with states FILL, LAUNCH, WAIT and RESP, plus a word counter cnt of 6 bits covering 0..WORDS-1.
REQ-020 In FILL, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-021 An input word is accepted when in_valid and in_ready are both 1; the accepted in_data SHALL be written to bitmap[32*cnt+31 : 32*cnt], so word 0 lands at bitmap[31:0].
REQ-022 Bitmap bits not written in the current frame SHALL retain their previous values.
REQ-023 When a word is accepted with cnt < WORDS-1 and in_last = 0, cnt SHALL increment.
REQ-024 When a word is accepted with cnt < WORDS-1 and in_last = 1, the block SHALL pulse frame_err for one cycle, set cnt to 0, and remain in FILL.
REQ-025 When a word is accepted with cnt = WORDS-1 and in_last = 0, the block SHALL pulse frame_err for one cycle, set cnt to 0, and remain in FILL.
REQ-026 When a word is accepted with cnt = WORDS-1 and in_last = 1, the block SHALL go to LAUNCH and set cnt to 0.
REQ-027 In LAUNCH, wren SHALL be 1 for exactly one cycle with bitmap complete and stable; the next state SHALL be WAIT.
REQ-028 acc_done SHALL be ignored in LAUNCH, since it may be stale from the previous operation.
REQ-029 In WAIT, the first cycle with acc_done = 1 SHALL capture acc_result into res_data and move the block to RESP.
REQ-030 The WAIT watchdog SHALL count cycles spent in WAIT; on reaching TIMEOUT with acc_done = 0, the block SHALL pulse timeout for one cycle and return to FILL without touching res_data.
REQ-031 If acc_done = 1 in the same cycle the watchdog reaches TIMEOUT, acc_done SHALL win: the result is captured and no timeout pulse is produced.
REQ-032 In RESP, res_valid SHALL be 1 and res_data SHALL be held stable.
REQ-033 In RESP, on res_ready = 1 the block SHALL return to FILL.
REQ-034 In the cycle res_ready is accepted, in_ready SHALL remain 0; a new frame starts on the following cycle.
REQ-035 bitmap SHALL change only when words are accepted in FILL, and SHALL never change during LAUNCH, WAIT or RESP.
REQ-036 An in_valid pulse while in_ready = 0 SHALL be ignored, with no write and no count change.

Reset
REQ-037 While rst = 1 at a clock edge, the block SHALL set state to FILL, cnt to 0 and the watchdog to 0.
REQ-038 While rst = 1 at a clock edge, the block SHALL drive the following registered outputs to 0: bitmap, wren, res_valid, res_data, frame_err, timeout and busy.
REQ-039 in_ready SHALL be 0 during the reset cycle and 1 on the first cycle after rst deasserts.
REQ-040 A reset asserted in any state, including mid-frame, in WAIT, or in RESP, SHALL abandon the operation without producing a wren, frame_err or timeout pulse.

Verification
REQ-041 The bench SHALL cover a full frame: 48 words with in_data = k (word index) and in_last on word 47 -> one wren pulse exactly 1 cycle after word 47; bitmap[32k+31:32k] = k for all k.
REQ-042 The bench SHALL cover result return: acc_done pulsed 10 cycles after wren with acc_result = 16'h00A5 -> res_valid = 1 and res_data = 16'h00A5 held while res_ready = 0 for 5 cycles, then cleared 1 cycle after res_ready.
REQ-043 The bench SHALL cover a short frame: in_last on word 20 -> frame_err pulse, no wren, next word written to slot 0.
REQ-044 The bench SHALL cover a long frame: word 47 sent without in_last -> frame_err pulse, cnt = 0, no wren.
REQ-045 The bench SHALL cover the watchdog: no acc_done after wren, with TIMEOUT = 16 -> timeout pulse 16 cycles after entry to WAIT, then in_ready = 1, res_valid remains 0, and acc_done at cycle 16 suppresses the timeout.
REQ-046 The bench SHALL cover reset mid-frame and in WAIT: rst pulsed after word 30 and again in WAIT -> all outputs 0, no wren, and a fresh 48-word frame completes normally afterwards.
